ifetch_decode: RTL and testbench

Instruction fetch and decode stage that feeds the 32-bit ALU. It fetches RV32I instruction words from instruction memory over a req/ack handshake and splits each word into the decoded fields the ALU consumes: OPCODE, FUNCT3, FUNCT1, IMM12, U_IMM20, RS2, plus PC. It presents them downstream under a valid/ready handshake. It owns the fetch PC and accepts redirects from branch/jump resolution.

---
 rtl/ifetch_decode.sv | 133 +++++++++++++
 tb/tb_ifetch_decode.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_decode.sv
// ifetch_decode: RV32I fetch over req/ack, field decode, valid/ready output with redirect
module ifetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic        o_funct1,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [11:0] o_imm12,
  output logic [19:0] o_u_imm20
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic        r_valid;
  logic [31:0] w_tgt;
  logic [6:0]  w_op;
  logic [11:0] w_imm12;
  logic [19:0] w_u_imm20;
  logic        w_funct1;
  logic        w_load;

  assign w_tgt       = {i_redirect_pc[31:2], 2'b00};
  assign w_op        = i_imem_rdata[6:0];
  assign w_load      = (r_state == FETCH) && i_imem_ack && !i_redirect;
  assign o_imem_req  = (r_state == FETCH) || (r_state == DISCARD);
  assign o_imem_addr = r_req_addr;
  assign o_out_valid = r_valid;

  // Format-dependent immediate and ALU sub/sra select from the incoming word
  always_comb begin
    w_imm12   = (w_op == 7'b0100011) ? {i_imem_rdata[31:25], i_imem_rdata[11:7]} :
                (w_op == 7'b1100011) ? {i_imem_rdata[31], i_imem_rdata[7], i_imem_rdata[30:25], i_imem_rdata[11:8]} :
                i_imem_rdata[31:20];
    w_u_imm20 = (w_op == 7'b1101111) ? {i_imem_rdata[31], i_imem_rdata[19:12], i_imem_rdata[20], i_imem_rdata[30:21]} :
                i_imem_rdata[31:12];
    w_funct1  = ((w_op == 7'b0110011) || (w_op == 7'b0010011 && i_imem_rdata[14:12] == 3'b101)) ? i_imem_rdata[30] : 1'b0;
  end

  // Fetch control: redirect wins; an outstanding request always completes before refetching
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (i_redirect) begin
            r_fetch_pc <= w_tgt;
            r_req_addr <= w_tgt;
            r_valid    <= 1'b0;
            r_state    <= FETCH;
          end else if (r_state == IDLE) begin
            r_state <= FETCH;
          end else if (i_out_ready) begin
            r_valid    <= 1'b0;
            r_req_addr <= r_fetch_pc;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (i_redirect) begin
            r_fetch_pc <= w_tgt;
            r_req_addr <= i_imem_ack ? w_tgt : r_req_addr;
            r_state    <= i_imem_ack ? FETCH : DISCARD;
          end else if (i_imem_ack) begin
            r_valid    <= 1'b1;
            r_fetch_pc <= r_req_addr + 32'd4;
            r_state    <= HOLD;
          end
        end
        default: begin
          if (i_redirect) begin
            r_fetch_pc <= w_tgt;
            r_req_addr <= i_imem_ack ? w_tgt : r_req_addr;
            r_state    <= i_imem_ack ? FETCH : DISCARD;
          end else if (i_imem_ack) begin
            r_req_addr <= r_fetch_pc;
            r_state    <= FETCH;
          end
        end
      endcase
    end
  end

  // Output register: captured only when an accepted fetch completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc      <= '0;
      o_instr   <= '0;
      o_opcode  <= '0;
      o_funct3  <= '0;
      o_funct1  <= 1'b0;
      o_rs1     <= '0;
      o_rs2     <= '0;
      o_rd      <= '0;
      o_imm12   <= '0;
      o_u_imm20 <= '0;
    end else if (w_load) begin
      o_pc      <= r_req_addr;
      o_instr   <= i_imem_rdata;
      o_opcode  <= w_op;
      o_funct3  <= i_imem_rdata[14:12];
      o_funct1  <= w_funct1;
      o_rs1     <= i_imem_rdata[19:15];
      o_rs2     <= i_imem_rdata[24:20];
      o_rd      <= i_imem_rdata[11:7];
      o_imm12   <= w_imm12;
      o_u_imm20 <= w_u_imm20;
    end
  end
endmodule

// File: tb/tb_ifetch_decode.sv
// tb_ifetch_decode: directed checks of fetch sequencing, decode, stall, redirect and reset
module tb_ifetch_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct1;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm12;
  logic [19:0] u_imm20;
  logic [31:0] mem [16];
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[5:2]];

  ifetch_decode #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_pc(pc), .o_instr(instr), .o_opcode(opcode), .o_funct3(funct3),
    .o_funct1(funct1), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd),
    .o_imm12(imm12), .o_u_imm20(u_imm20)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h4020_8133;
    mem[1]  = 32'h0050_8093;
    mem[2]  = 32'h00C0_006F;
    mem[3]  = 32'hFE20_8EE3;
    mem[8]  = 32'h1234_50B7;
    mem[9]  = 32'h4030_D093;
    mem[15] = 32'h0000_0033;
    rst_n = 1'b0; imem_ack = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_imm12", {20'd0, imm12}, 32'h0);
    rst_n = 1'b1;
    #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
    // zero-wait streaming: sub, addi, jal, beq
    cyc();
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    cyc();
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_req", {31'd0, imem_req}, 32'd0);
    chk("sub_pc", pc, 32'h0);
    chk("sub_instr", instr, 32'h4020_8133);
    chk("sub_opcode", {25'd0, opcode}, 32'h33);
    chk("sub_funct1", {31'd0, funct1}, 32'd1);
    chk("sub_regs", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd2});
    cyc();
    chk("f1_valid", {31'd0, out_valid}, 32'd0);
    chk("f1_addr", imem_addr, 32'h4);
    cyc();
    chk("addi_pc", pc, 32'h4);
    chk("addi_opcode", {25'd0, opcode}, 32'h13);
    chk("addi_funct3", {29'd0, funct3}, 32'd0);
    chk("addi_funct1", {31'd0, funct1}, 32'd0);
    chk("addi_imm12", {20'd0, imm12}, 32'h005);
    cyc();
    chk("f2_addr", imem_addr, 32'h8);
    cyc();
    chk("jal_pc", pc, 32'h8);
    chk("jal_u_imm20", {12'd0, u_imm20}, 32'h00006);
    cyc();
    chk("f3_addr", imem_addr, 32'hC);
    out_ready = 1'b0;
    cyc();
    chk("beq_imm12", {20'd0, imm12}, 32'hFFE);
    chk("beq_u_imm20", {12'd0, u_imm20}, 32'hFE208);
    // stall: five cycles with ready low
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_pc", pc, 32'hC);
      chk("hold_instr", instr, 32'hFE20_8EE3);
      chk("hold_imm12", {20'd0, imm12}, 32'hFFE);
      if (i < 4) cyc();
    end
    out_ready = 1'b1; imem_ack = 1'b0;
    // delayed ack with redirect while the request is outstanding
    cyc();
    chk("acc_valid", {31'd0, out_valid}, 32'd0);
    chk("dly_req", {31'd0, imem_req}, 32'd1);
    chk("dly_addr", imem_addr, 32'h10);
    cyc();
    chk("dly_addr2", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cyc();
    redirect = 1'b0;
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    chk("disc_addr", imem_addr, 32'h10);
    cyc();
    imem_ack = 1'b1;
    cyc();
    chk("disc_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    cyc();
    chk("redir_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_pc", pc, 32'h100);
    // redirect in HOLD kills the presented instruction despite ready
    redirect = 1'b1; redirect_pc = 32'h0000_0022;
    cyc();
    redirect = 1'b0;
    chk("kill_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_addr", imem_addr, 32'h20);
    cyc();
    chk("lui_pc", pc, 32'h20);
    chk("lui_opcode", {25'd0, opcode}, 32'h37);
    chk("lui_u_imm20", {12'd0, u_imm20}, 32'h12345);
    cyc();
    chk("f_srai_addr", imem_addr, 32'h24);
    cyc();
    chk("srai_pc", pc, 32'h24);
    chk("srai_funct3", {29'd0, funct3}, 32'd5);
    chk("srai_funct1", {31'd0, funct1}, 32'd1);
    chk("srai_imm12", {20'd0, imm12}, 32'h403);
    imem_ack = 1'b0;
    cyc();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h28);
    // asynchronous reset mid-fetch
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", pc, 32'h0);
    cyc();
    imem_ack = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 5 && !imem_req; i++) cyc();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    cyc();
    chk("restart_pc", pc, 32'h0);
    chk("restart_instr", instr, 32'h4020_8133);
    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_instr", instr, 32'h0000_0033);
    cyc();
    chk("wrap_addr", imem_addr, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
